// File: rtl/boot_pkg.sv
// Shared types and widths for the boot loader: sequencer states, image regions and bus widths.
package boot_pkg;

    localparam int BOOT_ADDR_W = 17;
    localparam int BOOT_DATA_W = 8;

    typedef enum logic [2:0] {
        START = 3'd0,
        READ  = 3'd1,
        SETUP = 3'd2,
        WRITE = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SLICE     = 2'd0,
        LOOKAHEAD = 2'd1,
        CONTROL   = 2'd2
    } region_t;

endpackage

// File: rtl/boot_wait_timer.sv
// Loadable down-counter with a zero flag, paces the EEPROM access time.
// Latency: zero asserts the cycle after the counter reaches 0; load wins over decrement.
// Backpressure: none; counts only while en is high and saturates at 0.
module boot_wait_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/boot_loader.sv
// Copies slice, lookahead and microcode images from EEPROM into their SRAMs after reset.
// Latency: EEPROM_WAIT+3 cycles per byte; all outputs registered.
// Backpressure: none; the sequence free-runs and parks in DONE until the next reset.
module boot_loader
    import boot_pkg::*;
#(
    parameter int SLICE_DEPTH     = 131072,
    parameter int LOOKAHEAD_DEPTH = 512,
    parameter int CONTROL_DEPTH   = 4096,
    parameter int EEPROM_WAIT     = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SKIP,
    input  logic [BOOT_DATA_W-1:0] EEPROM_DATA,
    output logic [BOOT_ADDR_W-1:0] EEPROM_ADDR,
    output logic [1:0]             EEPROM_SEL,
    output logic                   EEPROM_N_OE,
    output logic [BOOT_ADDR_W-1:0] ADDR,
    output logic [BOOT_DATA_W-1:0] DATA,
    output logic                   MLU_SLICE_N_WE,
    output logic                   MLU_LOOKAHEAD_N_WE,
    output logic                   CONTROL_N_WE,
    output logic                   N_BOOTED
);

    localparam int TIMER_W = $clog2(EEPROM_WAIT) + 1;
    localparam logic [TIMER_W-1:0] WAIT_LOAD = TIMER_W'(EEPROM_WAIT - 1);
    localparam logic [BOOT_ADDR_W-1:0] SLICE_LAST     = BOOT_ADDR_W'(SLICE_DEPTH - 1);
    localparam logic [BOOT_ADDR_W-1:0] LOOKAHEAD_LAST = BOOT_ADDR_W'(LOOKAHEAD_DEPTH - 1);
    localparam logic [BOOT_ADDR_W-1:0] CONTROL_LAST   = BOOT_ADDR_W'(CONTROL_DEPTH - 1);

    state_t                 state_q, state_d;
    region_t                region_q, region_d;
    logic [BOOT_ADDR_W-1:0] addr_q, addr_d;
    logic [BOOT_ADDR_W-1:0] region_last;
    logic                   timer_load;
    logic                   timer_zero;

    logic                   n_booted_d;
    logic                   n_oe_d;
    logic                   slice_n_we_d;
    logic                   lookahead_n_we_d;
    logic                   control_n_we_d;
    logic [BOOT_DATA_W-1:0] data_d;

    boot_wait_timer #(
        .W (TIMER_W)
    ) u_wait (
        .clk      (CLK),
        .rst      (RST),
        .load     (timer_load),
        .load_val (WAIT_LOAD),
        .en       (state_q == READ),
        .zero     (timer_zero)
    );

    always_comb begin
        region_last = SLICE_LAST;
        case (region_q)
            LOOKAHEAD: region_last = LOOKAHEAD_LAST;
            CONTROL:   region_last = CONTROL_LAST;
            default:   region_last = SLICE_LAST;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= START;
            region_q <= SLICE;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            addr_q   <= addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        addr_d     = addr_q;
        timer_load = 1'b0;
        case (state_q)
            START: begin
                if (SKIP) begin
                    state_d = DONE;
                end else begin
                    state_d    = READ;
                    timer_load = 1'b1;
                end
            end
            READ: begin
                if (timer_zero) begin
                    state_d = SETUP;
                end
            end
            SETUP: state_d = WRITE;
            WRITE: state_d = HOLD;
            HOLD: begin
                timer_load = 1'b1;
                if (addr_q != region_last) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = READ;
                end else if (region_q != CONTROL) begin
                    region_d = region_t'(region_q + 2'd1);
                    addr_d   = '0;
                    state_d  = READ;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = START;
        endcase
    end

    // Outputs are decoded from the next state so they switch on the same edge as the FSM.
    always_comb begin
        n_booted_d       = (state_d != DONE);
        n_oe_d           = (state_d != READ);
        slice_n_we_d     = !((state_d == WRITE) && (region_d == SLICE));
        lookahead_n_we_d = !((state_d == WRITE) && (region_d == LOOKAHEAD));
        control_n_we_d   = !((state_d == WRITE) && (region_d == CONTROL));
        data_d           = DATA;
        if ((state_q == READ) && timer_zero) begin
            data_d = EEPROM_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            N_BOOTED           <= 1'b1;
            EEPROM_N_OE        <= 1'b1;
            MLU_SLICE_N_WE     <= 1'b1;
            MLU_LOOKAHEAD_N_WE <= 1'b1;
            CONTROL_N_WE       <= 1'b1;
            ADDR               <= '0;
            EEPROM_ADDR        <= '0;
            EEPROM_SEL         <= 2'd0;
            DATA               <= '0;
        end else begin
            N_BOOTED           <= n_booted_d;
            EEPROM_N_OE        <= n_oe_d;
            MLU_SLICE_N_WE     <= slice_n_we_d;
            MLU_LOOKAHEAD_N_WE <= lookahead_n_we_d;
            CONTROL_N_WE       <= control_n_we_d;
            ADDR               <= addr_d;
            EEPROM_ADDR        <= addr_d;
            EEPROM_SEL         <= region_d;
            DATA               <= data_d;
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: small images, skip, mid-write reset, depth-1 regions, sticky DONE.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        skip = 1'b0;
    logic        ovr_en = 1'b0;
    logic [7:0]  ovr_dat = 8'h00;
    logic [7:0]  eeprom_data;
    logic [16:0] eeprom_addr;
    logic [1:0]  eeprom_sel;
    logic        eeprom_n_oe;
    logic [16:0] addr;
    logic [7:0]  data;
    logic        slice_n_we, la_n_we, ctl_n_we, n_booted;

    logic        rst1 = 1'b1;
    logic        skip1 = 1'b0;
    logic [7:0]  eeprom_data1;
    logic [16:0] eeprom_addr1;
    logic [1:0]  eeprom_sel1;
    logic        eeprom_n_oe1;
    logic [16:0] addr1;
    logic [7:0]  data1;
    logic        slice_n_we1, la_n_we1, ctl_n_we1, n_booted1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign eeprom_data  = ovr_en ? ovr_dat : {eeprom_sel, eeprom_addr[5:0]};
    assign eeprom_data1 = {eeprom_sel1, eeprom_addr1[5:0]};

    boot_loader #(
        .SLICE_DEPTH(4), .LOOKAHEAD_DEPTH(2), .CONTROL_DEPTH(3), .EEPROM_WAIT(2)
    ) dut (
        .CLK(clk), .RST(rst), .SKIP(skip), .EEPROM_DATA(eeprom_data),
        .EEPROM_ADDR(eeprom_addr), .EEPROM_SEL(eeprom_sel), .EEPROM_N_OE(eeprom_n_oe),
        .ADDR(addr), .DATA(data), .MLU_SLICE_N_WE(slice_n_we),
        .MLU_LOOKAHEAD_N_WE(la_n_we), .CONTROL_N_WE(ctl_n_we), .N_BOOTED(n_booted)
    );

    boot_loader #(
        .SLICE_DEPTH(1), .LOOKAHEAD_DEPTH(1), .CONTROL_DEPTH(1), .EEPROM_WAIT(1)
    ) dut1 (
        .CLK(clk), .RST(rst1), .SKIP(skip1), .EEPROM_DATA(eeprom_data1),
        .EEPROM_ADDR(eeprom_addr1), .EEPROM_SEL(eeprom_sel1), .EEPROM_N_OE(eeprom_n_oe1),
        .ADDR(addr1), .DATA(data1), .MLU_SLICE_N_WE(slice_n_we1),
        .MLU_LOOKAHEAD_N_WE(la_n_we1), .CONTROL_N_WE(ctl_n_we1), .N_BOOTED(n_booted1)
    );

    // Recorder for the main instance; tasks compare deltas against their own baselines.
    int          log_kind[$];
    int          log_addr[$];
    int          log_data[$];
    int          slice_cnt = 0, la_cnt = 0, ctl_cnt = 0;
    int          overlap_cnt = 0, long_cnt = 0, unstable_cnt = 0, oe_low_cnt = 0;
    logic [2:0]  lows, prev_lows = 3'b000;
    logic [16:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;

    always @(negedge clk) begin
        lows = {~ctl_n_we, ~la_n_we, ~slice_n_we};
        if ($countones(lows) > 1) overlap_cnt++;
        if (lows != 3'b000) begin
            if (lows == prev_lows) long_cnt++;
            if (addr !== prev_addr || data !== prev_data) unstable_cnt++;
            log_kind.push_back(lows[0] ? 0 : (lows[1] ? 1 : 2));
            log_addr.push_back(int'(addr));
            log_data.push_back(int'(data));
            if (lows[0]) slice_cnt++;
            if (lows[1]) la_cnt++;
            if (lows[2]) ctl_cnt++;
        end
        if (prev_lows != 3'b000 && rst === 1'b0 && (addr !== prev_addr || data !== prev_data))
            unstable_cnt++;
        if (eeprom_n_oe === 1'b0) oe_low_cnt++;
        prev_lows = lows;
        prev_addr = addr;
        prev_data = data;
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (n_booted !== 1'b1) begin bad++; $display("FAIL reset_n_booted got=%b exp=1", n_booted); end
        total++; if ({slice_n_we, la_n_we, ctl_n_we} !== 3'b111) begin bad++; $display("FAIL reset_n_we got=%b exp=111", {slice_n_we, la_n_we, ctl_n_we}); end
        total++; if (eeprom_n_oe !== 1'b1) begin bad++; $display("FAIL reset_n_oe got=%b exp=1", eeprom_n_oe); end
        total++; if (addr !== 17'd0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", addr); end
        total++; if (data !== 8'd0) begin bad++; $display("FAIL reset_data got=%0h exp=0", data); end
        total++; if (eeprom_addr !== 17'd0) begin bad++; $display("FAIL reset_eeprom_addr got=%0h exp=0", eeprom_addr); end
        total++; if (eeprom_sel !== 2'd0) begin bad++; $display("FAIL reset_eeprom_sel got=%0d exp=0", eeprom_sel); end
    endtask

    task automatic test_happy_path();
        int exp_kind[9] = '{0, 0, 0, 0, 1, 1, 2, 2, 2};
        int exp_addr[9] = '{0, 1, 2, 3, 0, 1, 0, 1, 2};
        int exp_data[9] = '{'h00, 'h01, 'h02, 'h03, 'h40, 'h41, 'h80, 'h81, 'h82};
        int base, edges, idx, gk, ga, gd;
        bit done;
        base = log_kind.size();
        apply_reset();
        edges = 0; done = 0;
        while (!done && edges < 200) begin
            @(posedge clk); edges++;
            @(negedge clk);
            if (n_booted === 1'b0) done = 1;
        end
        // One START edge plus 9 bytes of 5 cycles each.
        total++; if (!done || edges != 46) begin bad++; $display("FAIL happy_done_edges got=%0d done=%0d exp=46", edges, done); end
        total++; if (log_kind.size() - base != 9) begin bad++; $display("FAIL happy_write_count got=%0d exp=9", log_kind.size() - base); end
        for (int i = 0; i < 9; i++) begin
            idx = base + i;
            gk = (idx < log_kind.size()) ? log_kind[idx] : -1;
            ga = (idx < log_addr.size()) ? log_addr[idx] : -1;
            gd = (idx < log_data.size()) ? log_data[idx] : -1;
            total++;
            if (gk != exp_kind[i] || ga != exp_addr[i] || gd != exp_data[i]) begin
                bad++;
                $display("FAIL happy_write%0d got kind=%0d addr=%0h data=%0h exp kind=%0d addr=%0h data=%0h",
                         i, gk, ga, gd, exp_kind[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_strobes();
        int s0, l0, c0, o0, g0, u0, edges;
        s0 = slice_cnt; l0 = la_cnt; c0 = ctl_cnt; o0 = overlap_cnt; g0 = long_cnt; u0 = unstable_cnt;
        apply_reset();
        edges = 0;
        while (n_booted !== 1'b0 && edges < 200) begin
            @(posedge clk); edges++;
            @(negedge clk);
        end
        total++; if (slice_cnt - s0 != 4) begin bad++; $display("FAIL strobe_slice_count got=%0d exp=4", slice_cnt - s0); end
        total++; if (la_cnt - l0 != 2) begin bad++; $display("FAIL strobe_lookahead_count got=%0d exp=2", la_cnt - l0); end
        total++; if (ctl_cnt - c0 != 3) begin bad++; $display("FAIL strobe_control_count got=%0d exp=3", ctl_cnt - c0); end
        total++; if (overlap_cnt - o0 != 0) begin bad++; $display("FAIL strobe_overlap got=%0d exp=0", overlap_cnt - o0); end
        total++; if (long_cnt - g0 != 0) begin bad++; $display("FAIL strobe_width got=%0d multi-cycle strobes exp=0", long_cnt - g0); end
        total++; if (unstable_cnt - u0 != 0) begin bad++; $display("FAIL strobe_addr_data_stable got=%0d changes exp=0", unstable_cnt - u0); end
    endtask

    task automatic test_skip();
        int w0, oe0;
        w0 = log_kind.size(); oe0 = oe_low_cnt;
        @(negedge clk);
        skip = 1'b1;
        apply_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (n_booted !== 1'b0) begin bad++; $display("FAIL skip_n_booted got=%b exp=0", n_booted); end
        skip = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (log_kind.size() - w0 != 0) begin bad++; $display("FAIL skip_no_writes got=%0d exp=0", log_kind.size() - w0); end
        total++; if (oe_low_cnt - oe0 != 0) begin bad++; $display("FAIL skip_n_oe_high got=%0d low cycles exp=0", oe_low_cnt - oe0); end
    endtask

    task automatic test_reset_mid_write();
        int base, edges, gk, ga;
        bit found, done;
        apply_reset();
        found = 0; edges = 0;
        while (!found && edges < 200) begin
            @(posedge clk); edges++;
            @(negedge clk);
            if (la_n_we === 1'b0 && addr === 17'd1) found = 1;
        end
        total++; if (!found) begin bad++; $display("FAIL midrst_reach_write got=not-found exp=found"); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if ({slice_n_we, la_n_we, ctl_n_we} !== 3'b111) begin bad++; $display("FAIL midrst_n_we_release got=%b exp=111", {slice_n_we, la_n_we, ctl_n_we}); end
        total++; if (addr !== 17'd0 || n_booted !== 1'b1) begin bad++; $display("FAIL midrst_reset_vals got addr=%0h n_booted=%b exp addr=0 n_booted=1", addr, n_booted); end
        base = log_kind.size();
        rst = 1'b0;
        edges = 0; done = 0;
        while (!done && edges < 200) begin
            @(posedge clk); edges++;
            @(negedge clk);
            if (n_booted === 1'b0) done = 1;
        end
        total++; if (!done || edges != 46) begin bad++; $display("FAIL midrst_done_edges got=%0d done=%0d exp=46", edges, done); end
        total++; if (log_kind.size() - base != 9) begin bad++; $display("FAIL midrst_write_count got=%0d exp=9", log_kind.size() - base); end
        gk = (base < log_kind.size()) ? log_kind[base] : -1;
        ga = (base < log_addr.size()) ? log_addr[base] : -1;
        total++; if (gk != 0 || ga != 0) begin bad++; $display("FAIL midrst_first_write got kind=%0d addr=%0h exp kind=0 addr=0", gk, ga); end
    endtask

    task automatic test_depth_one();
        int kinds[4], addrs[4], datas[4], sels[4];
        int nw, edges;
        bit done;
        @(negedge clk);
        rst1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst1 = 1'b0;
        nw = 0; edges = 0; done = 0;
        while (!done && edges < 100) begin
            @(posedge clk); edges++;
            @(negedge clk);
            if ({slice_n_we1, la_n_we1, ctl_n_we1} != 3'b111 && nw < 4) begin
                kinds[nw] = !slice_n_we1 ? 0 : (!la_n_we1 ? 1 : 2);
                addrs[nw] = int'(addr1);
                datas[nw] = int'(data1);
                sels[nw]  = int'(eeprom_sel1);
                nw++;
            end
            if (n_booted1 === 1'b0) done = 1;
        end
        // One START edge plus 3 bytes of 4 cycles each.
        total++; if (!done || edges != 13) begin bad++; $display("FAIL depth1_done_edges got=%0d done=%0d exp=13", edges, done); end
        total++; if (nw != 3) begin bad++; $display("FAIL depth1_write_count got=%0d exp=3", nw); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= nw || kinds[i] != i || addrs[i] != 0 || datas[i] != i * 64 || sels[i] != i) begin
                bad++;
                $display("FAIL depth1_write%0d got kind=%0d addr=%0h data=%0h sel=%0d exp kind=%0d addr=0 data=%0h sel=%0d",
                         i, kinds[i], addrs[i], datas[i], sels[i], i, i * 64, i);
            end
        end
    endtask

    task automatic test_done_sticky();
        logic [49:0] snap, now;
        int diffs;
        @(negedge clk);
        snap = {eeprom_addr, eeprom_sel, eeprom_n_oe, addr, data, slice_n_we, la_n_we, ctl_n_we, n_booted};
        diffs = 0;
        ovr_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ovr_dat = 8'($urandom);
            skip = i[0];
            @(negedge clk);
            now = {eeprom_addr, eeprom_sel, eeprom_n_oe, addr, data, slice_n_we, la_n_we, ctl_n_we, n_booted};
            if (now !== snap) diffs++;
        end
        ovr_en = 1'b0;
        skip = 1'b0;
        total++; if (n_booted !== 1'b0) begin bad++; $display("FAIL sticky_n_booted got=%b exp=0", n_booted); end
        total++; if (diffs != 0) begin bad++; $display("FAIL sticky_outputs got=%0d changed cycles exp=0", diffs); end
    endtask

    initial begin
        test_reset();
        test_happy_path();
        test_strobes();
        test_skip();
        test_reset_mid_write();
        test_depth_one();
        test_done_sticky();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
